// File: rtl/token_rl_pkg.sv
// Shared constants and types for the token-bucket limiter and its requester.
package token_rl_pkg;

    localparam int unsigned TRL_WAIT_W = 16;

    typedef logic [TRL_WAIT_W-1:0] trl_wait_t;

endpackage : token_rl_pkg

// File: rtl/issuer_fifo.sv
// Synchronous job FIFO for token_req_issuer; pointers wrap modulo DEPTH (power of 2).
module issuer_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DW-1:0]              wr_data_i,
    input  logic                       rd_en_i,
    output logic [DW-1:0]              rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr, do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : issuer_fifo

// File: rtl/token_req_issuer.sv
// Requester front-end for the token-bucket limiter: queues jobs, drives req/grant, issues pulses.
// Optional head-of-line drop on starvation is enabled by defining TOKEN_REQ_ISSUER_DROP_EN.
module token_req_issuer
    import token_rl_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          req_o,
    input  logic          grant_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic          stall_o,
    output logic          drop_o,
    output logic          err_o
);

    localparam int unsigned CW         = $clog2(DEPTH) + 1;
    localparam trl_wait_t   MAX_WAIT_W = trl_wait_t'(MAX_WAIT);

    logic [CW-1:0] count;
    logic [DW-1:0] head;
    logic          full, empty;
    logic          push, pop, drop;

    logic          pend_q, err_q, out_valid_q;
    logic [DW-1:0] out_data_q;
    trl_wait_t     wait_q, wait_d;

    issuer_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_data_i (in_data_i),
        .rd_en_i   (pop || drop),
        .rd_data_o (head),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign push = in_valid_i && !full;
    assign pop  = grant_i && pend_q;

`ifdef TOKEN_REQ_ISSUER_DROP_EN
    // >= rather than ==: a deferred drop (pend=1 at threshold) is taken once the answer is in.
    assign drop = !pend_q && !empty && (wait_q >= MAX_WAIT_W);
`else
    assign drop = 1'b0;
`endif

    // The job being dropped is not requested, so no grant can target a vanished head.
    assign req_o = !drop && (count > CW'(pend_q));

    always_comb begin
        wait_d = wait_q;
        if (empty || pop || drop) begin
            wait_d = '0;
        end else if (wait_q != '1) begin
            wait_d = wait_q + trl_wait_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wait_q      <= '0;
        end else begin
            pend_q      <= req_o;
            err_q       <= err_q || (grant_i && !pend_q);
            out_valid_q <= pop;
            if (pop) begin
                out_data_q <= head;
            end
            wait_q      <= wait_d;
        end
    end

`ifdef TOKEN_REQ_ISSUER_DROP_EN
    logic drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop;
        end
    end

    assign drop_o = drop_q;
`else
    assign drop_o = 1'b0;
`endif

    assign in_ready_o  = !full;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign stall_o     = (wait_q >= MAX_WAIT_W);
    assign err_o       = err_q;

endmodule : token_req_issuer

// File: tb/tb_token_req_issuer.sv
// Self-checking bench for token_req_issuer against a queue-based reference model.
module tb_token_req_issuer;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MW    = 4;
`ifdef TOKEN_REQ_ISSUER_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          req_o;
    logic          grant_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          stall_o;
    logic          drop_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    bit            m_pend, m_err, e_ov, e_drop;
    logic [DW-1:0] e_od;
    int unsigned   m_wait;

    token_req_issuer #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .req_o       (req_o),
        .grant_i     (grant_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .stall_o     (stall_o),
        .drop_o      (drop_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        grant_i    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_pend = 0; m_err = 0; m_wait = 0;
        e_ov = 0; e_od = '0; e_drop = 0;
        #1;
        chk("rst_req",   req_o,       0);
        chk("rst_ready", in_ready_o,  1);
        chk("rst_ov",    out_valid_o, 0);
        chk("rst_od",    out_data_o,  0);
        chk("rst_stall", stall_o,     0);
        chk("rst_drop",  drop_o,      0);
        chk("rst_err",   err_o,       0);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit g);
        int unsigned cnt;
        bit          mdrop, mreq, pop;
        in_valid_i = v;
        in_data_i  = d;
        grant_i    = g;
        #1;
        cnt   = q.size();
        mdrop = DROP_EN && !m_pend && cnt > 0 && m_wait >= MW;
        mreq  = !mdrop && (cnt > (m_pend ? 1 : 0));
        chk("req",   req_o,       mreq);
        chk("ready", in_ready_o,  cnt < DEPTH);
        chk("ov",    out_valid_o, e_ov);
        if (e_ov) chk("od", out_data_o, e_od);
        chk("stall", stall_o,     m_wait >= MW);
        chk("drop",  drop_o,      e_drop);
        chk("err",   err_o,       m_err);

        pop = g && m_pend;
        if (g && !m_pend) m_err = 1;
        e_ov = pop && cnt > 0;
        if (e_ov) e_od = q[0];
        e_drop = mdrop;
        if ((pop || mdrop) && cnt > 0) void'(q.pop_front());
        if (cnt == 0 || pop || mdrop) m_wait = 0;
        else if (m_wait < 65535) m_wait++;
        if (v && cnt < DEPTH) q.push_back(d);
        m_pend = mreq;
        @(negedge clk);
    endtask

    // Well-behaved limiter: answers only outstanding requests, granting when allowed.
    task automatic lim(input bit v, input logic [DW-1:0] d, input bit allow);
        step(v, d, m_pend && allow);
    endtask

    initial begin
        logic [DW-1:0] burst[8];
        int            idx;
        bit            tog;
        int            drops;

        rst_n = 1'b0; in_valid_i = 1'b0; in_data_i = '0; grant_i = 1'b0;
        @(negedge clk);
        do_reset();

        // Single job, always-granting limiter: req in c+1, issue in c+3
        lim(1, 16'hA5A5, 1);
        chk("single_req_c1", req_o, 1);
        lim(0, '0, 1);
        chk("single_req_c2", req_o, 0);
        chk("single_ov_c2", out_valid_o, 0);
        lim(0, '0, 1);
        chk("single_ov_c3", out_valid_o, 1);
        chk("single_od_c3", out_data_o, 16'hA5A5);
        lim(0, '0, 1);
        chk("single_ov_c4", out_valid_o, 0);

        // Burst of 8 with denials fills the FIFO, then drain with alternating grants
        do_reset();
        for (int i = 0; i < 8; i++) begin
            burst[i] = DW'($urandom);
            step(1, burst[i], 0);
        end
        chk("burst_full_ready", in_ready_o, 0);
        step(1, 16'hDEAD, 0);
        idx = 0;
        tog = 1;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            bit g;
            g = m_pend && tog;
            if (m_pend) tog = !tog;
            step(0, '0, g);
            if (out_valid_o) begin
                chk("burst_order", out_data_o, (idx < 8) ? burst[idx] : 16'hxxxx);
                idx++;
            end
        end
        chk("burst_issued", idx, 8);
        repeat (3) lim(0, '0, 1);
        chk("burst_empty_req", req_o, 0);

        // Spurious grant with empty FIFO
        step(0, '0, 1);
        chk("spur_err", err_o, 1);
        chk("spur_ov", out_valid_o, 0);
        repeat (4) step(0, '0, 0);
        chk("spur_err_sticky", err_o, 1);
        do_reset();

        // Grant in the first cycle after reset sees no pending request
        step(0, '0, 1);
        chk("post_rst_err", err_o, 1);
        do_reset();

        // Starvation with grants held low
        step(1, 16'h1234, 0);
        for (int c = 1; c < 5; c++) step(0, '0, 0);
        chk("starve_stall_c5", stall_o, 1);
        if (DROP_EN) begin
            drops = 0;
            for (int c = 0; c < 12; c++) begin
                lim(0, '0, 1);
                if (drop_o) drops++;
                chk("starve_no_issue", out_valid_o, 0);
            end
            chk("starve_drops", drops, 1);
            chk("starve_empty_req", req_o, 0);
            chk("starve_stall_clr", stall_o, 0);
        end else begin
            step(0, '0, 0);
            step(0, '0, 1);
            chk("starve_issue_ov", out_valid_o, 1);
            chk("starve_issue_od", out_data_o, 16'h1234);
            chk("starve_stall_clr", stall_o, 0);
            chk("starve_no_drop", drop_o, 0);
        end

        // Randomized traffic with occasional spurious grants and mid-run resets
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            bit v, g;
            if (i % 400 == 399) do_reset();
            v = ($urandom % 3) != 0;
            g = m_pend ? (($urandom % 4) != 0) : (($urandom % 80) == 0);
            step(v, DW'($urandom), g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_token_req_issuer
